param_serializer: RTL and testbench
===================================

# param_serializer

Parametrised bit serializer that replaces the fixed 16-bit serializer in the lab datapath. It accepts a parallel word of DATA_W bits with a per-word length and bit-order selection through a valid/ready handshake, then emits the selected bits one per clock on a serial output with a qualifying valid. It sits between the parallel data source and the serial link stage and reports a drop pulse for words with illegal lengths.

## Interface
- DATA_W, 16: parallel word width; power of two, ≥ 4.
- MIN_LEN, 3: smallest legal non-zero length; 1 ≤ MIN_LEN ≤ DATA_W.
- MOD_W, $clog2(DATA_W): width of the length field (derived, not overridden).
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- data_i  in  DATA_W  parallel word.
- data_mod_i  in  MOD_W  length; 0 means DATA_W bits.
- msb_first_i  in  1  1: MSB-first from data_i[DATA_W-1]; 0: LSB-first from data_i[0].
- data_val_i  in  1  word valid.
- ready_o  out  1  block can accept a word this cycle.
- ser_data_o  out  1  serial bit.
- ser_data_val_o  out  1  ser_data_o is valid.
- busy_o  out  1  serialization in progress.
- drop_o  out  1  one-cycle pulse: a word with an illegal length was consumed.

## Operation
- Length N = DATA_W when data_mod_i == 0, otherwise N = data_mod_i.
- Legal: N ≥ MIN_LEN. Illegal (1 ≤ data_mod_i < MIN_LEN): word consumed, no serial output, drop_o = 1 next cycle.
- Accept = data_val_i & ready_o. data_i, N and msb_first_i are sampled on accept; later input changes have no effect on the word in flight.
- MSB-first: outputs data_i[DATA_W-1], data_i[DATA_W-2], …, data_i[DATA_W-N]. LSB-first: data_i[0], data_i[1], …, data_i[N-1].
- States: IDLE and SHIFT. IDLE → SHIFT on a legal accept. SHIFT → IDLE after the Nth bit unless a back-to-back accept occurs (see Configuration).
- Remaining-bit counter width MOD_W+1; it is loaded with N and decremented once per output bit. No wrap-around is permitted.
- ser_data_o is forced to 0 whenever ser_data_val_o = 0.
- ser_data_val_o = busy_o.

## Timing
- Reset values: ready_o = 1, ser_data_o = 0, ser_data_val_o = 0, busy_o = 0, drop_o = 0. The state returns to IDLE and the counter and shift register are cleared.
- Reset asserted mid-word aborts the word immediately and asynchronously. No bits are emitted after reset is released until a new accept.
- Latency: accept at cycle T gives the first bit at T+1 and the last bit at T+N, with ser_data_val_o high for exactly N consecutive cycles.
- ready_o is combinational from registered state only; it has no combinational path from data_val_i.
- data_val_i while ready_o = 0 is ignored. The source holds the word until it is accepted.
- An illegal word is accepted only when ready_o = 1. drop_o pulses at T+1 and the state does not change.

## Configuration
- PARAM_SERIALIZER_B2B_EN defined: ready_o = 1 in IDLE and also during the last bit of SHIFT (remaining == 1). An accept on that cycle reloads directly, so the next word's first bit follows the previous last bit with zero bubble. A back-to-back illegal word ends SHIFT → IDLE and pulses drop_o.
- Not defined: ready_o = ~busy_o. There is at least one idle cycle (ser_data_val_o = 0) between consecutive words.

## Structure
- Package param_serializer_pkg holds the state enum (IDLE, SHIFT) and a length-decode function (data_mod_i → N, legal flag) parametrised via DATA_W/MIN_LEN arguments.
- One sub-module, param_serializer_shreg, is natural. It is a DATA_W-bit load/shift register with a direction select. MSB-first shifts left and outputs the MSB; LSB-first shifts right and outputs the LSB.
- The top level holds the FSM, counter, handshake and drop logic.

## Test plan
- Reset, then data_i = 16'hA5C3, data_mod_i = 0, msb_first_i = 1 → 16 valid bits 1010_0101_1100_0011, first bit at T+1, busy_o low at T+17.
- data_i = 16'h00F1, data_mod_i = 5, msb_first_i = 0 → bits 1,0,0,0,1, then ser_data_val_o = 0.
- data_mod_i = 1 and then 2 with MIN_LEN = 3 → drop_o pulses once each, ser_data_val_o stays 0, ready_o stays 1.
- Two legal 4-bit words with data_val_i held high → with PARAM_SERIALIZER_B2B_EN: 8 contiguous valid cycles. Without it: exactly one gap cycle between the words.
- data_val_i pulsed while busy (macro undefined) → ignored, and the output stream is unchanged.
- rst_n_i asserted at bit 7 of a 16-bit word → all outputs 0 immediately. After release, nothing is emitted until the next accept.

Source files
------------

// File: rtl/param_serializer_pkg.sv
// Shared types and length decode for the parametrised bit serializer.
// Optional feature macro used by the top level: PARAM_SERIALIZER_B2B_EN.
package param_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length field of zero selects the full word width. The returned value
    // is the bit count N. The legal flag reports N >= min_len.
    function automatic int unsigned decode_len(
        input  int unsigned data_w,
        input  int unsigned min_len,
        input  int unsigned mod,
        output logic        legal
    );
        int unsigned n;
        n     = (mod == 0) ? data_w : mod;
        legal = (n >= min_len);
        return n;
    endfunction

endpackage

// File: rtl/param_serializer_shreg.sv
// DATA_W-bit load/shift register with a per-word direction select.
// MSB-first shifts left and presents the MSB; LSB-first shifts right and
// presents the LSB. A load takes priority over a shift, so a new word can be
// loaded on the same cycle that the previous word's last bit is shown.
module param_serializer_shreg #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              msb_first_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ser_bit_o
);

    logic [DATA_W-1:0] sh_q;
    logic              msb_q;

    // Captures the word and its direction on load, then shifts toward the output end.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q  <= '0;
            msb_q <= 1'b0;
        end else if (load_i) begin
            sh_q  <= data_i;
            msb_q <= msb_first_i;
        end else if (shift_i) begin
            if (msb_q) begin
                sh_q <= {sh_q[DATA_W-2:0], 1'b0};
            end else begin
                sh_q <= {1'b0, sh_q[DATA_W-1:1]};
            end
        end
    end

    assign ser_bit_o = msb_q ? sh_q[DATA_W-1] : sh_q[0];

endmodule

// File: rtl/param_serializer.sv
// Parametrised serializer top: handshake, length decode, FSM, remaining-bit
// down-counter and drop pulse. Define PARAM_SERIALIZER_B2B_EN to allow a new
// word to be accepted during the last bit of the current one (no bubble).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word in flight; ready for a new word
// SHIFT | emitting bits; cnt_q holds the bits left including the one shown
module param_serializer
    import param_serializer_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int MIN_LEN = 3,
    localparam int MOD_W   = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              msb_first_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o,
    output logic              drop_o
);

    localparam int CNT_W = MOD_W + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             load, shift;
    logic [CNT_W-1:0] len_n;
    logic             len_legal;
    logic             busy, last_bit, accept;
    logic             ser_bit;

    // Decodes the incoming length field into a bit count and a legality flag.
    always_comb begin
        len_legal = 1'b0;
        len_n     = CNT_W'(decode_len(DATA_W, MIN_LEN, 32'(data_mod_i), len_legal));
    end

    assign busy     = (state_q == SHIFT);
    assign last_bit = busy && (cnt_q == CNT_W'(1));

`ifdef PARAM_SERIALIZER_B2B_EN
    assign ready_o = ~busy | last_bit;
`else
    assign ready_o = ~busy;
`endif

    assign accept = data_val_i & ready_o;

    // State, counter and drop registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: start, count down, reload back-to-back, or flag an illegal length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_legal) begin
                        state_d = SHIFT;
                        cnt_d   = len_n;
                        load    = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (last_bit) begin
                    if (accept && len_legal) begin
                        cnt_d = len_n;
                        load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        drop_d  = accept;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    param_serializer_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (load),
        .shift_i     (shift),
        .msb_first_i (msb_first_i),
        .data_i      (data_i),
        .ser_bit_o   (ser_bit)
    );

    assign ser_data_o     = busy & ser_bit;
    assign ser_data_val_o = busy;
    assign busy_o         = busy;
    assign drop_o         = drop_q;

endmodule

// File: tb/tb_param_serializer.sv
// Directed self-checking bench for param_serializer (DATA_W=16, MIN_LEN=3).
module tb_param_serializer;

    localparam int DATA_W  = 16;
    localparam int MIN_LEN = 3;
    localparam int MOD_W   = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [MOD_W-1:0]  data_mod_i = '0;
    logic              msb_first_i = 1'b0;
    logic              data_val_i = 1'b0;
    logic              ready_o;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;
    logic              drop_o;

    int n_checks = 0;
    int n_fail   = 0;

    param_serializer #(
        .DATA_W  (DATA_W),
        .MIN_LEN (MIN_LEN)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .msb_first_i    (msb_first_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o),
        .drop_o         (drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        data_val_i  = 1'b0;
        data_i      = '0;
        data_mod_i  = '0;
        msb_first_i = 1'b0;
    endtask

    // Called at a negedge with the block idle; the word is accepted at the next posedge.
    task automatic accept_word(input logic [15:0] d, input logic [3:0] m, input logic msb);
        data_i      = d;
        data_mod_i  = m;
        msb_first_i = msb;
        data_val_i  = 1'b1;
        @(posedge clk_i);
        #1;
        data_val_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b1 || ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 ||
            busy_o !== 1'b0 || drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b dat=%b val=%b busy=%b drop=%b expected 1 0 0 0 0",
                     ready_o, ser_data_o, ser_data_val_o, busy_o, drop_o);
        end
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b1 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0 || drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b val=%b busy=%b drop=%b expected 1 0 0 0",
                     ready_o, ser_data_val_o, busy_o, drop_o);
        end
    endtask

    task automatic test_msb_full();
        logic [15:0] exp_w;
        exp_w = 16'hA5C3;
        accept_word(16'hA5C3, 4'd0, 1'b1);
        // Input changes after accept must not affect the word in flight.
        data_i      = 16'h0000;
        data_mod_i  = 4'd3;
        msb_first_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (ser_data_val_o !== 1'b1 || busy_o !== 1'b1 || ser_data_o !== exp_w[15-i]) begin
                n_fail++;
                $display("FAIL msb_full bit %0d: val=%b busy=%b dat=%b expected 1 1 %b",
                         i, ser_data_val_o, busy_o, ser_data_o, exp_w[15-i]);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (ser_data_val_o !== 1'b0 || busy_o !== 1'b0 || ser_data_o !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_full_end: val=%b busy=%b dat=%b expected 0 0 0",
                     ser_data_val_o, busy_o, ser_data_o);
        end
        idle_inputs();
    endtask

    task automatic test_lsb_short();
        logic [15:0] exp_w;
        exp_w = 16'h00F1;
        accept_word(16'h00F1, 4'd5, 1'b0);
        data_i = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (ser_data_val_o !== 1'b1 || ser_data_o !== exp_w[i]) begin
                n_fail++;
                $display("FAIL lsb_short bit %0d: val=%b dat=%b expected 1 %b",
                         i, ser_data_val_o, ser_data_o, exp_w[i]);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if (ser_data_val_o !== 1'b0 || ser_data_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_short_end: val=%b dat=%b expected 0 0", ser_data_val_o, ser_data_o);
        end
        idle_inputs();
    endtask

    task automatic test_illegal_len();
        for (int m = 1; m <= 2; m++) begin
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_ready_pre len=%0d: rdy=%b expected 1", m, ready_o);
            end
            accept_word(16'hFFFF, 4'(m), 1'b1);
            @(negedge clk_i);
            n_checks++;
            if (drop_o !== 1'b1 || ser_data_val_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_pulse len=%0d: drop=%b val=%b rdy=%b busy=%b expected 1 0 1 0",
                         m, drop_o, ser_data_val_o, ready_o, busy_o);
            end
            @(negedge clk_i);
            n_checks++;
            if (drop_o !== 1'b0 || ser_data_val_o !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_after len=%0d: drop=%b val=%b expected 0 0",
                         m, drop_o, ser_data_val_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [0:10] ev;
        logic [0:10] ed;
        int          acc;
        logic        will_acc;
`ifdef PARAM_SERIALIZER_B2B_EN
        ev = 11'b11111111000;
        ed = 11'b10100101000;
`else
        ev = 11'b11110111100;
        ed = 11'b10100010100;
`endif
        acc         = 0;
        data_i      = 16'hA000;
        data_mod_i  = 4'd4;
        msb_first_i = 1'b1;
        data_val_i  = 1'b1;
        for (int c = 0; c < 11; c++) begin
            will_acc = data_val_i & ready_o;
            @(posedge clk_i);
            #1;
            if (will_acc) begin
                acc++;
                if (acc == 1) data_i = 16'h5000;
                else          data_val_i = 1'b0;
            end
            @(negedge clk_i);
            n_checks++;
            if (ser_data_val_o !== ev[c] || ser_data_o !== ed[c]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: val=%b dat=%b expected %b %b",
                         c, ser_data_val_o, ser_data_o, ev[c], ed[c]);
            end
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL back_to_back_accepts: got %0d expected 2", acc);
        end
        idle_inputs();
    endtask

    task automatic test_ignore_busy();
        logic [15:0] exp_w;
        exp_w = 16'hA5C3;
        accept_word(16'hA5C3, 4'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (i == 2) begin
                n_checks++;
                if (ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_busy_ready: rdy=%b expected 0", ready_o);
                end
                data_i      = 16'hFFFF;
                data_mod_i  = 4'd0;
                msb_first_i = 1'b0;
                data_val_i  = 1'b1;
            end else if (i == 3) begin
                data_val_i = 1'b0;
            end
            n_checks++;
            if (ser_data_val_o !== 1'b1 || ser_data_o !== exp_w[15-i]) begin
                n_fail++;
                $display("FAIL ignore_busy bit %0d: val=%b dat=%b expected 1 %b",
                         i, ser_data_val_o, ser_data_o, exp_w[15-i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (ser_data_val_o !== 1'b0 || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore_busy_end %0d: val=%b rdy=%b expected 0 1",
                         i, ser_data_val_o, ready_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_w;
        exp_w = 16'hA5C3;
        accept_word(16'hA5C3, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
        end
        n_checks++;
        if (ser_data_val_o !== 1'b1 || ser_data_o !== exp_w[8]) begin
            n_fail++;
            $display("FAIL reset_mid_bit7: val=%b dat=%b expected 1 %b",
                     ser_data_val_o, ser_data_o, exp_w[8]);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0 || busy_o !== 1'b0 ||
            drop_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: dat=%b val=%b busy=%b drop=%b rdy=%b expected 0 0 0 0 1",
                     ser_data_o, ser_data_val_o, busy_o, drop_o, ready_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (ser_data_val_o !== 1'b0 || ser_data_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet %0d: val=%b dat=%b expected 0 0",
                         i, ser_data_val_o, ser_data_o);
            end
        end
        accept_word(16'h00F1, 4'd5, 1'b0);
        @(negedge clk_i);
        n_checks++;
        if (ser_data_val_o !== 1'b1 || ser_data_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: val=%b dat=%b expected 1 1", ser_data_val_o, ser_data_o);
        end
        repeat (6) @(negedge clk_i);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_msb_full();
        test_lsb_short();
        test_illegal_len();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
